// File: rtl/core_pkg.sv
// Shared RV32 core definitions: load/store op codes and
// the memory sequencer state encoding.
package core_pkg;

   localparam logic [5:0] ALU_LB   = 6'd0;
   localparam logic [5:0] ALU_LH   = 6'd1;
   localparam logic [5:0] ALU_LW   = 6'd2;
   localparam logic [5:0] ALU_LD   = 6'd3;
   localparam logic [5:0] ALU_LBU  = 6'd4;
   localparam logic [5:0] ALU_SB   = 6'd15;
   localparam logic [5:0] ALU_SH   = 6'd16;
   localparam logic [5:0] ALU_SW   = 6'd17;
   localparam logic [5:0] ALU_JALR = 6'd35;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

   function automatic logic is_load(input logic [5:0] op);
      return op == ALU_LB || op == ALU_LH
          || op == ALU_LW || op == ALU_LBU;
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return op == ALU_SB || op == ALU_SH
          || op == ALU_SW;
   endfunction

   // LD is excluded: RV32 has no 64-bit load.
   function automatic logic is_legal(input logic [5:0] op);
      return is_load(op) || is_store(op);
   endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Handshaked data-memory port between the load/store
// sequencer (master) and the data memory (slave).
interface mem_access_sequencer_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr,
      output mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr,
      input  mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, load
// extraction with sign/zero extension, misalign check.
module mem_lane_align
   import core_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  a,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic        misalign
);

   logic [7:0]  rb;
   logic [15:0] rh;

   assign rb = rdata[{a, 3'b000} +: 8];
   assign rh = a[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be       = '0;
      wdata    = '0;
      ldata    = '0;
      misalign = 1'b0;
      unique case (op)
         ALU_LB:  ldata = {{24{rb[7]}}, rb};
         ALU_LBU: ldata = {24'b0, rb};
         ALU_LH: begin
            ldata    = {{16{rh[15]}}, rh};
            misalign = a[0];
         end
         ALU_LW: begin
            ldata    = rdata;
            misalign = |a;
         end
         ALU_SB: begin
            be    = 4'b0001 << a;
            wdata = {4{store_data[7:0]}};
         end
         ALU_SH: begin
            be       = a[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{store_data[15:0]}};
            misalign = a[0];
         end
         ALU_SW: begin
            be       = 4'b1111;
            wdata    = store_data;
            misalign = |a;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer: stalls the core while a
// data-memory access is outstanding, reports done/fault.
module mem_access_sequencer
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  aluOP,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        done,
   output logic        fault,
   output logic [31:0] load_data,
   mem_access_sequencer_if.master mem
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   seq_state_t  state, state_n;
   logic [5:0]  op_q;
   logic [1:0]  a_q;
   logic [7:0]  cnt;
   logic        fault_q;
   logic [31:0] ld_q;

   logic [5:0]  la_op;
   logic [1:0]  la_a;
   logic [3:0]  la_be;
   logic [31:0] la_wdata;
   logic [31:0] la_ldata;
   logic        la_mis;
   logic        ok;
   logic        to_hit;

   // Idle decodes the incoming op; REQ extracts with the latched one.
   assign la_op = (state == S_IDLE) ? aluOP : op_q;
   assign la_a  = (state == S_IDLE) ? addr[1:0] : a_q;

   mem_lane_align u_align (
      .op         (la_op),
      .a          (la_a),
      .store_data (store_data),
      .rdata      (mem.mem_rdata),
      .be         (la_be),
      .wdata      (la_wdata),
      .ldata      (la_ldata),
      .misalign   (la_mis)
   );

   assign ok     = is_legal(aluOP) && !la_mis;
   assign to_hit = (cnt == TO_LAST);

   assign stall = (state == S_IDLE && start)
               || (state == S_REQ);
   assign done      = (state == S_DONE);
   assign fault     = done & fault_q;
   assign load_data = done ? ld_q : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:
            if (start) state_n = ok ? S_REQ : S_DONE;
         S_REQ:
            if (mem.mem_ack || to_hit) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q          <= '0;
         a_q           <= '0;
         cnt           <= '0;
         fault_q       <= 1'b0;
         ld_q          <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
      end else if (state == S_IDLE && start) begin
         op_q    <= aluOP;
         a_q     <= addr[1:0];
         cnt     <= '0;
         ld_q    <= '0;
         fault_q <= !ok;
         if (ok) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store(aluOP);
            mem.mem_addr  <= {addr[31:2], 2'b00};
            mem.mem_be    <= la_be;
            mem.mem_wdata <= la_wdata;
         end
      end else if (state == S_REQ) begin
         // Ack in the timeout cycle still completes cleanly.
         if (mem.mem_ack || to_hit) begin
            fault_q       <= !mem.mem_ack;
            ld_q          <= (mem.mem_ack && is_load(op_q))
                           ? la_ldata : '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with TIMEOUT=4.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  aluOP;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        stall;
   logic        done;
   logic        fault;
   logic [31:0] load_data;

   int nvec = 0;
   int nmis = 0;

   mem_access_sequencer_if mif ();

   mem_access_sequencer #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .aluOP      (aluOP),
      .addr       (addr),
      .store_data (store_data),
      .stall      (stall),
      .done       (done),
      .fault      (fault),
      .load_data  (load_data),
      .mem        (mif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   // Legal access with `waits` cycles before ack.
   task automatic xact(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic [31:0] sd,
                       input logic [31:0] rd,
                       input int waits,
                       input logic [3:0] ebe,
                       input logic [31:0] ewd,
                       input logic ewe,
                       input logic [31:0] eld);
      @(posedge clk); #1;
      start = 1'b1; aluOP = op;
      addr = a; store_data = sd;
      @(negedge clk);
      chk("stall_T", 32'(stall), 32'd1);
      chk("req_T", 32'(mif.mem_req), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         mif.mem_ack   = (i == waits);
         mif.mem_rdata = (i == waits) ? rd : 32'hDEADBEEF;
         @(negedge clk);
         chk("req", 32'(mif.mem_req), 32'd1);
         chk("addr", mif.mem_addr, a & 32'hFFFF_FFFC);
         chk("be", 32'(mif.mem_be), 32'(ebe));
         chk("we", 32'(mif.mem_we), 32'(ewe));
         if (ewe) chk("wdata", mif.mem_wdata, ewd);
         chk("stall_req", 32'(stall), 32'd1);
         chk("done_req", 32'(done), 32'd0);
         @(posedge clk); #1;
         mif.mem_ack = 1'b0;
      end
      @(negedge clk);
      chk("done", 32'(done), 32'd1);
      chk("fault", 32'(fault), 32'd0);
      chk("load_data", load_data, eld);
      chk("stall_done", 32'(stall), 32'd0);
      chk("req_done", 32'(mif.mem_req), 32'd0);
   endtask

   // Op rejected in IDLE: done+fault next cycle, no request.
   task automatic fxact(input logic [5:0] op,
                        input logic [31:0] a);
      @(posedge clk); #1;
      start = 1'b1; aluOP = op;
      addr = a; store_data = 32'h5555_AAAA;
      @(negedge clk);
      chk("f_stall_T", 32'(stall), 32'd1);
      chk("f_req_T", 32'(mif.mem_req), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("f_done", 32'(done), 32'd1);
      chk("f_fault", 32'(fault), 32'd1);
      chk("f_req", 32'(mif.mem_req), 32'd0);
      chk("f_ld", load_data, 32'd0);
      chk("f_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; aluOP = '0;
      addr = '0; store_data = '0;
      mif.mem_ack = 1'b0; mif.mem_rdata = '0;

      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_req", 32'(mif.mem_req), 32'd0);
      chk("rst_ld", load_data, 32'd0);
      start = 1'b1; #1;
      chk("rst_stall_start", 32'(stall), 32'd1);
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      // LB / LBU at 0x103, lane 3 holds 0x80
      xact(6'd0, 32'h103, 32'h0, 32'h80FF_0000, 0,
           4'b0000, 32'h0, 1'b0, 32'hFFFF_FF80);
      xact(6'd4, 32'h103, 32'h0, 32'h80FF_0000, 0,
           4'b0000, 32'h0, 1'b0, 32'h0000_0080);
      xact(6'd15, 32'h101, 32'h0000_005A, 32'h0, 0,
           4'b0010, 32'h5A5A_5A5A, 1'b1, 32'h0);
      xact(6'd16, 32'h202, 32'h1234_ABCD, 32'h0, 0,
           4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0);
      xact(6'd1, 32'h002, 32'h0, 32'h8001_1234, 0,
           4'b0000, 32'h0, 1'b0, 32'hFFFF_8001);
      xact(6'd1, 32'h000, 32'h0, 32'h8001_1234, 1,
           4'b0000, 32'h0, 1'b0, 32'h0000_1234);

      fxact(6'd2, 32'h301);
      fxact(6'd3, 32'h300);
      fxact(6'd16, 32'h201);
      fxact(6'd5, 32'h300);

      // SW with no ack: 4 request cycles, then timeout fault
      @(posedge clk); #1;
      start = 1'b1; aluOP = 6'd17;
      addr = 32'h400; store_data = 32'h1122_3344;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to_req", 32'(mif.mem_req), 32'd1);
         chk("to_done", 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to_done_end", 32'(done), 32'd1);
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_req_end", 32'(mif.mem_req), 32'd0);

      // Ack on the 4th request cycle beats the timeout
      xact(6'd17, 32'h400, 32'h1122_3344, 32'h0, 3,
           4'b1111, 32'h1122_3344, 1'b1, 32'h0);
      // LW with 3 wait cycles, then back-to-back start
      xact(6'd2, 32'h300, 32'h0, 32'hCAFE_F00D, 3,
           4'b0000, 32'h0, 1'b0, 32'hCAFE_F00D);
      xact(6'd2, 32'h304, 32'h0, 32'h0BAD_BEEF, 0,
           4'b0000, 32'h0, 1'b0, 32'h0BAD_BEEF);

      // Reset while a request is outstanding
      @(posedge clk); #1;
      start = 1'b1; aluOP = 6'd2; addr = 32'h500;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("mr_req_before", 32'(mif.mem_req), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("mr_req", 32'(mif.mem_req), 32'd0);
      chk("mr_stall", 32'(stall), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mr_idle_done", 32'(done), 32'd0);
         chk("mr_idle_req", 32'(mif.mem_req), 32'd0);
         chk("mr_idle_stall", 32'(stall), 32'd0);
      end
      xact(6'd2, 32'h500, 32'h0, 32'h1357_9BDF, 0,
           4'b0000, 32'h0, 1'b0, 32'h1357_9BDF);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nmis);
      $finish;
   end

endmodule
